// File: rtl/memsync_pkg.sv
// Definitions shared between MEMSync and its row-mover stage: geometry defaults,
// mover FSM states and the {row, beat} address helper.
package memsync_pkg;

  localparam int DEF_CHWIDTH    = 6;
  localparam int DEF_ADDRWIDTH  = 17;
  localparam int DEF_BURSTWIDTH = 3;
  localparam int DEF_DATAWIDTH  = 64;
  localparam int DEF_BEATS      = 1 << DEF_BURSTWIDTH;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WB_RD,
    ST_WB_LAT,
    ST_WB_SEND,
    ST_FILL,
    ST_DONE
  } mover_state_t;

  // Beat-granular address {row, beat}; callers cast the result to their own width.
  function automatic logic [31:0] row_beat_addr(input logic [31:0] row,
                                                input logic [31:0] beat,
                                                input int          beat_bits);
    return (row << beat_bits) | beat;
  endfunction

endpackage

// File: rtl/memsync_row_mover.sv
// Moves one cache row to/from backing memory per MEMSync request and pulses
// sync when the row transfer has completed.
module memsync_row_mover
  import memsync_pkg::*;
#(
  parameter int CHWIDTH    = DEF_CHWIDTH,
  parameter int ADDRWIDTH  = DEF_ADDRWIDTH,
  parameter int BURSTWIDTH = DEF_BURSTWIDTH,
  parameter int DATAWIDTH  = DEF_DATAWIDTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic                            req_wb,
  input  logic [CHWIDTH-1:0]              req_crow,
  input  logic [ADDRWIDTH-1:0]            req_row,
  output logic                            sync,
  output logic                            c_en,
  output logic                            c_we,
  output logic [CHWIDTH+BURSTWIDTH-1:0]   c_addr,
  output logic [DATAWIDTH-1:0]            c_wdata,
  input  logic [DATAWIDTH-1:0]            c_rdata,
  output logic                            b_valid,
  input  logic                            b_ready,
  output logic                            b_write,
  output logic [ADDRWIDTH+BURSTWIDTH-1:0] b_addr,
  output logic [DATAWIDTH-1:0]            b_wdata,
  input  logic                            b_rvalid,
  input  logic [DATAWIDTH-1:0]            b_rdata,
  output logic                            err
);

  localparam int N_BEATS = 1 << BURSTWIDTH;
  localparam int TXW     = BURSTWIDTH + 1;
  localparam int CAW     = CHWIDTH + BURSTWIDTH;
  localparam int BAW     = ADDRWIDTH + BURSTWIDTH;
  localparam logic [TXW-1:0]        TX_LAST = TXW'(N_BEATS - 1);
  localparam logic [BURSTWIDTH-1:0] RX_LAST = BURSTWIDTH'(N_BEATS - 1);

  mover_state_t r_state, w_next_state;

  logic                  r_wb;
  logic [CHWIDTH-1:0]    r_crow;
  logic [ADDRWIDTH-1:0]  r_row;
  logic [TXW-1:0]        r_tx_beat;   // extra MSB marks "every command issued"
  logic [BURSTWIDTH-1:0] r_rx_beat;
  logic [DATAWIDTH-1:0]  r_wbuf;
  logic                  r_err;

  logic           w_accept;
  logic           w_tx_inc;
  logic           w_rx_inc;
  logic           w_stray_return;
  logic [CAW-1:0] w_c_tx_addr;
  logic [CAW-1:0] w_c_rx_addr;
  logic [BAW-1:0] w_b_addr;

  assign req_ready      = (r_state == ST_IDLE);
  assign w_accept       = req_valid && req_ready;
  assign w_stray_return = b_rvalid && (r_state != ST_FILL);
  assign err            = r_err;

  assign w_c_tx_addr = CAW'(row_beat_addr(32'(r_crow), 32'(r_tx_beat[BURSTWIDTH-1:0]), BURSTWIDTH));
  assign w_c_rx_addr = CAW'(row_beat_addr(32'(r_crow), 32'(r_rx_beat), BURSTWIDTH));
  assign w_b_addr    = BAW'(row_beat_addr(32'(r_row), 32'(r_tx_beat[BURSTWIDTH-1:0]), BURSTWIDTH));

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_wb      <= 1'b0;
      r_crow    <= '0;
      r_row     <= '0;
      r_tx_beat <= '0;
      r_rx_beat <= '0;
      r_wbuf    <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_wb      <= req_wb;
        r_crow    <= req_crow;
        r_row     <= req_row;
        r_tx_beat <= '0;
        r_rx_beat <= '0;
      end
      if (w_tx_inc) r_tx_beat <= r_tx_beat + TXW'(1);
      if (w_rx_inc) r_rx_beat <= r_rx_beat + BURSTWIDTH'(1);
      if (r_state == ST_WB_LAT) r_wbuf <= c_rdata;
      if (w_stray_return) r_err <= 1'b1;
    end
  end

  // NOTE: every output and next-state signal gets a default before the case,
  // so no path through this block can infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_tx_inc     = 1'b0;
    w_rx_inc     = 1'b0;
    sync         = 1'b0;
    c_en         = 1'b0;
    c_we         = 1'b0;
    c_addr       = '0;
    c_wdata      = '0;
    b_valid      = 1'b0;
    b_write      = 1'b0;
    b_addr       = '0;
    b_wdata      = '0;

    case (r_state)
      ST_IDLE: begin
        if (req_valid) w_next_state = req_wb ? ST_WB_RD : ST_FILL;
      end
      ST_WB_RD: begin
        c_en         = 1'b1;
        c_addr       = w_c_tx_addr;
        w_next_state = ST_WB_LAT;
      end
      ST_WB_LAT: begin
        w_next_state = ST_WB_SEND;
      end
      ST_WB_SEND: begin
        b_valid = 1'b1;
        b_write = r_wb;
        b_addr  = w_b_addr;
        b_wdata = r_wbuf;
        if (b_ready) begin
          if (r_tx_beat == TX_LAST) begin
            w_next_state = ST_DONE;
          end else begin
            w_tx_inc     = 1'b1;
            w_next_state = ST_WB_RD;
          end
        end
      end
      ST_FILL: begin
        // Read commands and returns run independently; returns land in the cache as they arrive.
        b_valid  = !r_tx_beat[BURSTWIDTH];
        b_write  = r_wb;
        b_addr   = b_valid ? w_b_addr : '0;
        w_tx_inc = b_valid && b_ready;
        if (b_rvalid) begin
          c_en     = 1'b1;
          c_we     = 1'b1;
          c_addr   = w_c_rx_addr;
          c_wdata  = b_rdata;
          w_rx_inc = 1'b1;
          if (r_rx_beat == RX_LAST) w_next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        sync         = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

endmodule

// File: doc/memsync_row_mover.md
Name: memsync_row_mover

Overview:
- Data-movement stage directly downstream of MEMSync.
- While MEMSync sits in WriteBack or Allocate with stall high, it issues one row-transfer request to this block:
  - WriteBack copies a dirty cache row (cRowId) out to backing memory.
  - Allocate fills a cache row from a backing-memory row (RowId).
- On completion this block drives MEMSync's `sync` input with a one-cycle pulse, releasing the MEMSync FSM.
- Cache side is a 1-cycle-latency SRAM port; backing side is a valid/ready command channel with an in-order read-return channel.

Parameters:
- CHWIDTH, 6, cache row index width (64 cache rows)
- ADDRWIDTH, 17, backing row index width
- BURSTWIDTH, 3, log2 beats per row (8 beats)
- DATAWIDTH, 64, beat width in bits

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low (0 = reset)
- req_valid  in  1  transfer request
- req_ready  out  1  block idle, can accept a request
- req_wb  in  1  1 = writeback (cache->backing), 0 = allocate/fill (backing->cache)
- req_crow  in  CHWIDTH  cache row (cRowId)
- req_row  in  ADDRWIDTH  backing row (RowId)
- sync  out  1  one-cycle completion pulse to MEMSync
- c_en  out  1  cache port enable
- c_we  out  1  cache write enable
- c_addr  out  CHWIDTH+BURSTWIDTH  {crow, beat}
- c_wdata  out  DATAWIDTH  cache write data
- c_rdata  in  DATAWIDTH  cache read data, valid 1 cycle after c_en && !c_we
- b_valid  out  1  backing command valid
- b_ready  in  1  backing command accept
- b_write  out  1  1 = write beat, 0 = read beat
- b_addr  out  ADDRWIDTH+BURSTWIDTH  {row, beat}
- b_wdata  out  DATAWIDTH  write beat data
- b_rvalid  in  1  read-return beat valid (in order, no backpressure)
- b_rdata  in  DATAWIDTH  read-return data
- err  out  1  sticky protocol error

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE; all counters 0.
  - sync, c_en, c_we, b_valid, b_write, err = 0; req_ready = 1 after reset.
  - Data/address outputs = 0.
  - Reset mid-transfer aborts the transfer with no sync pulse.
- Accept: req_valid && req_ready latches req_wb, req_crow and req_row; req_ready drops the next cycle.
- States: IDLE, WB_RD, WB_LAT, WB_SEND, FILL, DONE.
- IDLE:
  - On accept: req_wb=1 -> WB_RD; req_wb=0 -> FILL. Beat counters cleared.
- WB_RD:
  - c_en=1, c_we=0, c_addr={crow, tx_beat}. Go to WB_LAT.
- WB_LAT:
  - Capture c_rdata into wbuf. Go to WB_SEND.
- WB_SEND:
  - b_valid=1, b_write=1, b_addr={row, tx_beat}, b_wdata=wbuf.
  - Hold all of these stable until b_ready.
  - On b_ready: if tx_beat == 2^BURSTWIDTH-1, go to DONE; else tx_beat++ and go to WB_RD.
  - Minimum 3 cycles per beat.
- FILL:
  - Command side: b_valid=1, b_write=0, b_addr={row, tx_beat} while tx_beat < 2^BURSTWIDTH. tx_beat++ on each b_ready. b_valid drops after the last command is accepted.
  - Return side, concurrently: each b_rvalid gives c_en=1, c_we=1, c_addr={crow, rx_beat}, c_wdata=b_rdata in the same cycle (combinational), then rx_beat++.
  - Go to DONE when the last beat (rx_beat = 2^BURSTWIDTH-1) is written.
  - Returns may overlap commands. A return in the same cycle as the accept of the command it answers is allowed.
- DONE:
  - sync=1 for exactly one cycle, then IDLE.
  - req_ready is 0 in DONE, so the earliest new accept is the cycle after sync.
- Counters: tx_beat is BURSTWIDTH+1 bits to represent "all issued"; rx_beat is BURSTWIDTH bits.
- Boundary and error cases:
  - b_rvalid outside FILL: ignored, err set.
  - b_rvalid in FILL after all beats have been returned: ignored, err set.
  - err clears only on reset.
  - req_valid while busy: ignored; no queueing.
  - b_ready while b_valid=0: no effect.
- Latency, writeback with b_ready tied 1: 3 cycles per beat, so 24 cycles + DONE = sync pulse at cycle 25 after accept.
- Latency, fill with b_ready=1 and 1-cycle return: sync at cycle 2^BURSTWIDTH+2 after accept.

Decomposition:
- Package memsync_pkg:
  - state enum mover_state_t.
  - Beat-count localparam.
  - Address-concatenation helper functions.
  - Shared with MEMSync for the CHWIDTH/ADDRWIDTH defaults.
- No sub-module required.
- Optional: a beat_counter sub-module (up-counter with terminal flag), instantiated twice for tx and rx.

Test Plan:
- Writeback, b_ready=1:
  - Stimulus: req_wb=1, crow=5, row=0x1ABCD; cache model preloaded beat k = 0xA5A5_0000+k.
  - Expected: 8 b_write beats, b_addr 0xD5E68..0xD5E6F, data in order; sync exactly once at cycle 25; req_ready back to 1 after sync.
- Fill with random b_ready and a return delay of 1-4 cycles:
  - Stimulus: req_wb=0, crow=63, row=0; backing model beat k = ~k.
  - Expected: cache addrs 0x1F8..0x1FF written with ~k in order; exactly 8 read commands; single sync.
- Backpressure hold:
  - Stimulus: b_ready=0 for 10 cycles during WB_SEND beat 3.
  - Expected: b_valid, b_addr and b_wdata stable for all 10 cycles; no beat skipped or duplicated.
- Back-to-back MEMSync flow:
  - Stimulus: writeback request, then a fill request asserted in the sync cycle.
  - Expected: the fill is not accepted until the cycle after sync; two distinct sync pulses.
- Reset mid-fill:
  - Stimulus: rst=0 after 3 beats have returned.
  - Expected: next cycle all outputs are at reset values, no sync pulse, req_ready=1 after rst returns to 1.
- Spurious return:
  - Stimulus: b_rvalid=1 in IDLE.
  - Expected: no cache write; err=1 and stays 1 until reset.
